// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter and the processor/RAM wrappers.
// Holds the default bus widths, the read-owner encoding and the counter helper.
package data_ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    OWN_PROC = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  function automatic logic [3:0] satInc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Processor, host and RAM port bundle for the data RAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface data_ram_arbiter_if
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              proc_re;
  logic              proc_we;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_din;
  logic [DATA_W-1:0] proc_dout;
  logic              proc_stall;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              ram_read_en;
  logic              ram_write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  proc_re, proc_we, proc_addr, proc_din,
    input  host_req, host_we, host_addr, host_wdata,
    input  ram_dout,
    output proc_dout, proc_stall,
    output host_gnt, host_rvalid, host_rdata,
    output ram_read_en, ram_write_en, ram_addr, ram_din
  );

  modport master (
    output proc_re, proc_we, proc_addr, proc_din,
    output host_req, host_we, host_addr, host_wdata,
    output ram_dout,
    input  proc_dout, proc_stall,
    input  host_gnt, host_rvalid, host_rdata,
    input  ram_read_en, ram_write_en, ram_addr, ram_din
  );

endinterface

// File: rtl/data_ram_arbiter.sv
// Single-port data RAM arbiter: processor has priority, the host is granted
// when the processor is idle or after STARVE_LIMIT consecutive refusals.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input logic              clk,
  input logic              rst_n,
  data_ram_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              procReq;
  logic              hostWin;
  logic              procWin;
  logic              readEn;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramDin;

  logic [3:0]        waitCnt_q, waitCnt_d;
  logic              rdPending_q;
  owner_e            rdOwner_q;
  logic [DATA_W-1:0] procHold_q;
  logic [DATA_W-1:0] hostHold_q;

  // Grants are gated by rst_n so the RAM port is quiet while reset is held.
  always_comb begin
    procReq = bus.proc_re | bus.proc_we;
    hostWin = rst_n & bus.host_req & (~procReq | (waitCnt_q == LIMIT));
    procWin = rst_n & procReq & ~hostWin;

    readEn  = 1'b0;
    ramAddr = bus.proc_addr;
    ramDin  = bus.proc_din;
    bus.ram_write_en = 1'b0;
    if (hostWin) begin
      readEn           = ~bus.host_we;
      bus.ram_write_en = bus.host_we;
      ramAddr          = bus.host_addr;
      ramDin           = bus.host_wdata;
    end else if (procWin) begin
      readEn           = bus.proc_re;
      bus.ram_write_en = bus.proc_we;
    end
    bus.ram_read_en = readEn;
    bus.ram_addr    = ramAddr;
    bus.ram_din     = ramDin;

    bus.host_gnt   = hostWin;
    bus.proc_stall = rst_n & procReq & ~procWin;

    waitCnt_d = (hostWin | ~bus.host_req) ? 4'd0 : satInc4(waitCnt_q);
  end

  // Read data is live from the RAM in the return cycle and held afterwards.
  always_comb begin
    bus.host_rvalid = rdPending_q & (rdOwner_q == OWN_HOST);
    bus.host_rdata  = bus.host_rvalid ? bus.ram_dout : hostHold_q;
    bus.proc_dout   = (rdPending_q & (rdOwner_q == OWN_PROC)) ? bus.ram_dout : procHold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt_q   <= 4'd0;
      rdPending_q <= 1'b0;
      rdOwner_q   <= OWN_PROC;
      procHold_q  <= '0;
      hostHold_q  <= '0;
    end else begin
      waitCnt_q   <= waitCnt_d;
      rdPending_q <= readEn;
      if (readEn) begin
        rdOwner_q <= hostWin ? OWN_HOST : OWN_PROC;
      end
      if (rdPending_q && rdOwner_q == OWN_PROC) begin
        procHold_q <= bus.ram_dout;
      end
      if (rdPending_q && rdOwner_q == OWN_HOST) begin
        hostHold_q <= bus.ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: directed scenarios followed by
// randomized traffic compared against a shadow memory and grant-rule model.
module tb_data_ram_arbiter;

  localparam int AW    = 7;
  localparam int DW    = 16;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  data_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Synchronous RAM: write-first into the array, read data one cycle later.
  logic [DW-1:0] ramMem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_write_en) ramMem[bus.ram_addr] <= bus.ram_din;
    if (bus.ram_read_en)  bus.ram_dout <= ramMem[bus.ram_addr];
  end

  int compareCount  = 0;
  int mismatchCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic setProc(input logic re, input logic we, input int addr, input logic [DW-1:0] din);
    bus.proc_re   = re;
    bus.proc_we   = we;
    bus.proc_addr = AW'(addr);
    bus.proc_din  = din;
  endtask

  task automatic setHost(input logic req, input logic we, input int addr, input logic [DW-1:0] wdata);
    bus.host_req   = req;
    bus.host_we    = we;
    bus.host_addr  = AW'(addr);
    bus.host_wdata = wdata;
  endtask

  task automatic applyStimulus();
    setProc(1'b0, 1'b0, 0, '0);
    setHost(1'b0, 1'b0, 0, '0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rd_en"},  32'(bus.ram_read_en),  32'd0);
    checkOutput({tag, "_wr_en"},  32'(bus.ram_write_en), 32'd0);
    checkOutput({tag, "_gnt"},    32'(bus.host_gnt),     32'd0);
    checkOutput({tag, "_stall"},  32'(bus.proc_stall),   32'd0);
    checkOutput({tag, "_rvalid"}, 32'(bus.host_rvalid),  32'd0);
  endtask

  // Processor reads addr 3 every cycle while the host holds a read of addr 5.
  task automatic runContention(input string tag);
    for (int c = 1; c <= LIMIT + 2; c++) begin
      setProc(1'b1, 1'b0, 3, '0);
      setHost(1'b1, 1'b0, 5, '0);
      @(negedge clk);
      if (c == LIMIT + 1) begin
        checkOutput({tag, "_gnt_starved"},   32'(bus.host_gnt),   32'd1);
        checkOutput({tag, "_stall_starved"}, 32'(bus.proc_stall), 32'd1);
      end else begin
        checkOutput({tag, "_gnt_refused"},   32'(bus.host_gnt),   32'd0);
        checkOutput({tag, "_stall_none"},    32'(bus.proc_stall), 32'd0);
      end
      nextCycle();
    end
    applyStimulus();
    nextCycle();
  endtask

  logic [DW-1:0] shadow [0:(1<<AW)-1];

  initial begin
    logic          hostActive, hostWeH, procReq, expGnt, expStall;
    logic          curPendHost, curPendProc, nextPendHost, nextPendProc;
    logic          lastProcKnown, pRe, pWe;
    logic [DW-1:0] hostDataH, pendHostVal, pendProcVal, nextHostVal, nextProcVal;
    logic [DW-1:0] lastProcVal, pDin;
    int            hostAddrH, refused, hostWait, pAddr, pick;

    rst_n = 1'b0;
    setProc(1'b0, 1'b1, 4, 16'hAAAA);
    setHost(1'b1, 1'b1, 6, 16'h5555);
    repeat (2) begin
      @(negedge clk);
      checkResetOutputs("reset");
    end
    checkOutput("reset_proc_dout",  32'(bus.proc_dout),  32'd0);
    checkOutput("reset_host_rdata", 32'(bus.host_rdata), 32'd0);
    nextCycle();
    applyStimulus();
    rst_n = 1'b1;

    // Host-only write then read of address 5.
    setHost(1'b1, 1'b1, 5, 16'h1234);
    @(negedge clk);
    checkOutput("host_wr_gnt",   32'(bus.host_gnt),     32'd1);
    checkOutput("host_wr_en",    32'(bus.ram_write_en), 32'd1);
    checkOutput("host_wr_addr",  32'(bus.ram_addr),     32'd5);
    nextCycle();
    setHost(1'b1, 1'b0, 5, '0);
    @(negedge clk);
    checkOutput("host_rd_gnt",   32'(bus.host_gnt),     32'd1);
    checkOutput("host_rd_en",    32'(bus.ram_read_en),  32'd1);
    checkOutput("host_rd_early", 32'(bus.host_rvalid),  32'd0);
    nextCycle();
    applyStimulus();
    @(negedge clk);
    checkOutput("host_rvalid",   32'(bus.host_rvalid),  32'd1);
    checkOutput("host_rdata",    32'(bus.host_rdata),   32'h1234);
    nextCycle();
    @(negedge clk);
    checkOutput("host_rvalid_drop", 32'(bus.host_rvalid), 32'd0);

    // Processor-only write then read of address 3, plus preload of 1 and 2.
    nextCycle();
    setProc(1'b0, 1'b1, 3, 16'hBEEF);
    @(negedge clk);
    checkOutput("proc_wr_stall", 32'(bus.proc_stall), 32'd0);
    nextCycle();
    setProc(1'b1, 1'b0, 3, '0);
    @(negedge clk);
    checkOutput("proc_rd_stall", 32'(bus.proc_stall), 32'd0);
    nextCycle();
    setProc(1'b0, 1'b1, 1, 16'h0011);
    @(negedge clk);
    checkOutput("proc_dout_beef", 32'(bus.proc_dout), 32'hBEEF);
    nextCycle();
    setProc(1'b0, 1'b1, 2, 16'h0022);
    @(negedge clk);
    checkOutput("proc_dout_hold", 32'(bus.proc_dout), 32'hBEEF);

    // Interleaved reads must return to the side that issued them.
    nextCycle();
    setProc(1'b1, 1'b0, 1, '0);
    nextCycle();
    setProc(1'b0, 1'b0, 0, '0);
    setHost(1'b1, 1'b0, 2, '0);
    @(negedge clk);
    checkOutput("ilv_host_gnt",    32'(bus.host_gnt),    32'd1);
    checkOutput("ilv_proc_dout",   32'(bus.proc_dout),   32'h0011);
    checkOutput("ilv_no_rvalid",   32'(bus.host_rvalid), 32'd0);
    nextCycle();
    applyStimulus();
    @(negedge clk);
    checkOutput("ilv_host_rvalid", 32'(bus.host_rvalid), 32'd1);
    checkOutput("ilv_host_rdata",  32'(bus.host_rdata),  32'h0022);
    checkOutput("ilv_proc_keep",   32'(bus.proc_dout),   32'h0011);

    // Host write followed immediately by a processor read of the same word.
    nextCycle();
    setHost(1'b1, 1'b1, 9, 16'h5A5A);
    nextCycle();
    setHost(1'b0, 1'b0, 0, '0);
    setProc(1'b1, 1'b0, 9, '0);
    nextCycle();
    applyStimulus();
    @(negedge clk);
    checkOutput("wr_then_rd", 32'(bus.proc_dout), 32'h5A5A);
    nextCycle();

    runContention("starve");

    // Reset asserted during a host read grant cycle.
    setHost(1'b1, 1'b0, 5, '0);
    @(negedge clk);
    checkOutput("rst_gnt_before", 32'(bus.host_gnt), 32'd1);
    #2;
    rst_n = 1'b0;
    setProc(1'b1, 1'b0, 3, '0);
    #1;
    checkResetOutputs("rst_mid");
    nextCycle();
    @(negedge clk);
    checkResetOutputs("rst_held");
    nextCycle();
    applyStimulus();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_no_rvalid", 32'(bus.host_rvalid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("rst_no_rvalid2", 32'(bus.host_rvalid), 32'd0);

    // Build up a partial wait count, reset, and require a full starvation run.
    nextCycle();
    for (int c = 0; c < 5; c++) begin
      setProc(1'b1, 1'b0, 3, '0);
      setHost(1'b1, 1'b0, 5, '0);
      @(negedge clk);
      checkOutput("prewait_refused", 32'(bus.host_gnt), 32'd0);
      nextCycle();
    end
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    runContention("post_reset");

    // Randomized traffic against a shadow memory.
    for (int a = 0; a < (1 << AW); a++) begin
      shadow[a] = 16'($urandom);
      setProc(1'b0, 1'b1, a, shadow[a]);
      nextCycle();
    end
    applyStimulus();
    hostActive = 1'b0; hostWeH = 1'b0; hostAddrH = 0; hostDataH = '0;
    refused = 0; hostWait = 0;
    curPendHost = 1'b0; curPendProc = 1'b0;
    pendHostVal = '0; pendProcVal = '0;
    lastProcKnown = 1'b0; lastProcVal = '0;
    nextCycle();

    for (int cyc = 0; cyc < 10000; cyc++) begin
      pick  = $urandom_range(0, 3);
      pRe   = (pick == 1);
      pWe   = (pick == 2);
      pAddr = $urandom_range(0, 15);
      pDin  = 16'($urandom);
      setProc(pRe, pWe, pAddr, pDin);
      if (!hostActive && $urandom_range(0, 2) == 0) begin
        hostActive = 1'b1;
        hostWeH    = 1'($urandom_range(0, 1));
        hostAddrH  = $urandom_range(0, 15);
        hostDataH  = 16'($urandom);
        hostWait   = 0;
      end
      setHost(hostActive, hostWeH, hostAddrH, hostDataH);

      procReq  = pRe | pWe;
      expGnt   = hostActive && (!procReq || refused == LIMIT);
      expStall = procReq && expGnt;

      @(negedge clk);
      checkOutput("rnd_exclusive", 32'(bus.ram_read_en & bus.ram_write_en), 32'd0);
      checkOutput("rnd_host_gnt",  32'(bus.host_gnt),    32'(expGnt));
      checkOutput("rnd_stall",     32'(bus.proc_stall),  32'(expStall));
      checkOutput("rnd_rvalid",    32'(bus.host_rvalid), 32'(curPendHost));
      if (curPendHost) checkOutput("rnd_host_rdata", 32'(bus.host_rdata), 32'(pendHostVal));
      if (curPendProc) begin
        checkOutput("rnd_proc_dout", 32'(bus.proc_dout), 32'(pendProcVal));
        lastProcVal   = pendProcVal;
        lastProcKnown = 1'b1;
      end else if (lastProcKnown) begin
        checkOutput("rnd_proc_hold", 32'(bus.proc_dout), 32'(lastProcVal));
      end

      nextPendHost = 1'b0; nextPendProc = 1'b0;
      nextHostVal = '0; nextProcVal = '0;
      if (expGnt) begin
        checkOutput("rnd_wait_bound", 32'(hostWait + 1 <= LIMIT + 1), 32'd1);
        if (hostWeH) shadow[hostAddrH] = hostDataH;
        else begin
          nextPendHost = 1'b1;
          nextHostVal  = shadow[hostAddrH];
        end
        hostActive = 1'b0;
        refused    = 0;
      end else if (hostActive) begin
        refused++;
        hostWait++;
      end
      if (procReq && !expGnt) begin
        if (pWe) shadow[pAddr] = pDin;
        else begin
          nextPendProc = 1'b1;
          nextProcVal  = shadow[pAddr];
        end
      end

      nextCycle();
      curPendHost = nextPendHost; pendHostVal = nextHostVal;
      curPendProc = nextPendProc; pendProcVal = nextProcVal;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, data RAM word address width (128 words).
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter STARVE_LIMIT, default 8, range 1..15, max consecutive cycles a requesting host may be refused.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 proc_re / proc_we  in  1 each  processor data read / write request, one-cycle access, never both high.
REQ-007 proc_addr  in  ADDR_W  processor access address; proc_din  in  DATA_W  processor write data.
REQ-008 proc_dout  out  DATA_W  read data to processor; proc_stall  out  1  processor access not performed this cycle, hold and retry.
REQ-009 host_req  in  1  host access request; host_we  in  1  1=write, 0=read.
REQ-010 host_addr  in  ADDR_W  host address; host_wdata  in  DATA_W  host write data.
REQ-011 host_gnt  out  1  host access performed this cycle; host_rvalid  out  1  host_rdata valid; host_rdata  out  DATA_W.
REQ-012 ram_read_en / ram_write_en  out  1 each, ram_addr  out  ADDR_W, ram_din  out  DATA_W  to RAM data port; ram_dout  in  DATA_W  from RAM, valid one cycle after ram_read_en.

Function
REQ-013 The block SHALL issue at most one RAM access per cycle; ram_read_en and ram_write_en SHALL never be high together.
REQ-014 Grant is combinational from current requests and registered wait_cnt: host wins if host_req and (no proc request or wait_cnt == STARVE_LIMIT); otherwise processor wins if requesting; otherwise idle (all RAM enables 0).
REQ-015 Processor wins: RAM port driven from proc_* signals, proc_stall=0, host_gnt=0.
REQ-016 Host wins: RAM port driven from host_* signals, host_gnt=1, proc_stall=1 iff proc_re or proc_we high.
REQ-017 wait_cnt (4-bit): next = 0 when host_gnt or !host_req; else saturating +1 when host_req refused.
REQ-018 Host handshake: host holds req/we/addr/wdata stable until a rising edge with host_gnt=1; req held high afterwards starts next access, back-to-back grants allowed.
REQ-019 Registered rd_owner/rd_pending record the winner of each read; the cycle after a host read grant host_rvalid=1, host_rdata=ram_dout; otherwise host_rvalid=0.
REQ-020 proc_dout SHALL equal ram_dout in the cycle after a processor read grant; hold last processor read value otherwise (registered capture).
REQ-021 Host write then processor read of same address in next cycle SHALL return the new value (RAM write-first ordering, no bypass needed).
REQ-022 proc_stall SHALL be 0 whenever the processor is not requesting.

Reset
REQ-023 While rst_n=0: ram_read_en=0, ram_write_en=0, host_gnt=0, proc_stall=0 regardless of inputs.
REQ-024 Reset values: wait_cnt=0, host_rvalid=0, rd_pending=0, rd_owner=proc, proc_dout=0, host_rdata=0.
REQ-025 Reset mid-access SHALL drop any pending read return; no host_rvalid after release for pre-reset grant.

Structure
REQ-026 Shared package holds ADDR_W/DATA_W defaults and owner encoding constants (OWN_PROC=0, OWN_HOST=1) for reuse by the processor and RAM wrappers.
REQ-027 Single module, no sub-modules; starvation counter kept inline.

Verification
REQ-028 Host-only: host write 0x1234 to addr 5, then host read addr 5 -> host_gnt each cycle, host_rvalid=1 one cycle after read gnt, host_rdata=0x1234.
REQ-029 Proc-only: proc_we addr 3 data 0xBEEF, next cycle proc_re addr 3 -> proc_stall=0 throughout, proc_dout=0xBEEF one cycle after read.
REQ-030 Contention, STARVE_LIMIT=8: proc requesting every cycle, host_req held -> host refused 8 cycles, granted on 9th with proc_stall=1 that cycle only, wait_cnt back to 0.
REQ-031 Interleaved reads: proc read addr 1 (0x0011) and host read addr 2 (0x0022) in consecutive cycles -> data routed to correct side, never crossed, host_rvalid only for host read.
REQ-032 Reset during host read grant cycle -> no host_rvalid after release, all enables 0 while rst_n=0, wait_cnt=0.
REQ-033 Random proc/host traffic 10000 cycles vs. reference memory model -> no simultaneous RAM read/write, all read data match, no host wait exceeding STARVE_LIMIT+1 cycles.
